barrel_shifter_pipe: RTL and testbench



---
 rtl/barrel_shifter_pipe.sv | 174 +++++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
// Pipelined barrel shifter supporting rotate-right, rotate-left, logical
// shift-right and arithmetic shift-right. The shift amount is resolved one
// binary-weighted bit per stage: stage k shifts by 2^k when amount bit k is
// set. Every stage is registered, and a single global advance signal moves
// the whole pipe, which gives full valid/ready backpressure.
// WIDTH must be a power of two and at least 2.
module barrel_shifter_pipe #(
   parameter  int WIDTH = 8,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int S = AMT_W;

   localparam logic [1:0] MODE_ROR = 2'b00;
   localparam logic [1:0] MODE_ROL = 2'b01;
   localparam logic [1:0] MODE_LSR = 2'b10;
   localparam logic [1:0] MODE_ASR = 2'b11;

   // Shift one operand by a fixed amount in the requested mode. ASR fills
   // with the sign bit captured at the pipe entry, not with the current MSB
   // of the partially shifted word.
   function automatic logic [WIDTH-1:0] shift_stage(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       mode,
      input logic             sign,
      input int unsigned      sh
   );
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   r;
      dbl = {(2*WIDTH){1'b0}};
      r   = d;
      case (mode)
         MODE_ROR: begin
            dbl = {d, d} >> sh;
            r   = dbl[WIDTH-1:0];
         end
         MODE_ROL: begin
            dbl = {d, d} << sh;
            r   = dbl[2*WIDTH-1:WIDTH];
         end
         MODE_LSR: begin
            dbl = {{WIDTH{1'b0}}, d} >> sh;
            r   = dbl[WIDTH-1:0];
         end
         MODE_ASR: begin
            dbl = {{WIDTH{sign}}, d} >> sh;
            r   = dbl[WIDTH-1:0];
         end
         default: begin
            r = d;
         end
      endcase
      return r;
   endfunction

   // Stage registers and their next-state values
   logic [WIDTH-1:0] data_q [S];
   logic [WIDTH-1:0] data_d [S];
   logic [AMT_W-1:0] amt_q  [S];
   logic [AMT_W-1:0] amt_d  [S];
   logic [1:0]       mode_q [S];
   logic [1:0]       mode_d [S];
   logic [S-1:0]     valid_q;
   logic [S-1:0]     valid_d;
   logic [S-1:0]     sign_q;
   logic [S-1:0]     sign_d;

   // Per-stage source values (stage 0 from the input port, others from the
   // previous stage)
   logic [WIDTH-1:0] src_data [S];
   logic [AMT_W-1:0] src_amt  [S];
   logic [1:0]       src_mode [S];
   logic [S-1:0]     src_valid;
   logic [S-1:0]     src_sign;

   logic adv;

   // Global advance, handshake outputs and output taps from the last stage
   always_comb begin
      adv       = !valid_q[S-1] || out_ready;
      in_ready  = adv;
      out_valid = valid_q[S-1];
      out_data  = data_q[S-1];
   end

   // Select each stage's source; input fields are zeroed on bubbles so that
   // undriven/unknown input data never reaches the data registers
   always_comb begin
      src_valid    = {S{1'b0}};
      src_sign     = {S{1'b0}};
      src_valid[0] = in_valid;
      if (in_valid) begin
         src_data[0] = in_data;
         src_amt[0]  = in_amt;
         src_mode[0] = in_mode;
         src_sign[0] = in_data[WIDTH-1];
      end else begin
         src_data[0] = {WIDTH{1'b0}};
         src_amt[0]  = {AMT_W{1'b0}};
         src_mode[0] = 2'b00;
         src_sign[0] = 1'b0;
      end
      for (int k = 1; k < S; k++) begin
         src_data[k]  = data_q[k-1];
         src_amt[k]   = amt_q[k-1];
         src_mode[k]  = mode_q[k-1];
         src_valid[k] = valid_q[k-1];
         src_sign[k]  = sign_q[k-1];
      end
   end

   // Next-state: on advance every stage loads its source, applying its
   // 2^k shift when amount bit k is set; otherwise everything holds
   always_comb begin
      valid_d = valid_q;
      sign_d  = sign_q;
      for (int k = 0; k < S; k++) begin
         data_d[k] = data_q[k];
         amt_d[k]  = amt_q[k];
         mode_d[k] = mode_q[k];
      end
      if (adv) begin
         valid_d = src_valid;
         sign_d  = src_sign;
         for (int k = 0; k < S; k++) begin
            amt_d[k]  = src_amt[k];
            mode_d[k] = src_mode[k];
            if (src_amt[k][k]) begin
               data_d[k] = shift_stage(src_data[k], src_mode[k], src_sign[k],
                                       32'd1 << k);
            end else begin
               data_d[k] = src_data[k];
            end
         end
      end else begin
         valid_d = valid_q;
         sign_d  = sign_q;
      end
   end

   // Pipeline registers; reset discards every in-flight operand at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= {S{1'b0}};
         sign_q  <= {S{1'b0}};
         for (int k = 0; k < S; k++) begin
            data_q[k] <= {WIDTH{1'b0}};
            amt_q[k]  <= {AMT_W{1'b0}};
            mode_q[k] <= 2'b00;
         end
      end else begin
         valid_q <= valid_d;
         sign_q  <= sign_d;
         for (int k = 0; k < S; k++) begin
            data_q[k] <= data_d[k];
            amt_q[k]  <= amt_d[k];
            mode_q[k] <= mode_d[k];
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed testbench for barrel_shifter_pipe: an 8-bit instance exercises
// modes, streaming, backpressure and mid-stream reset; a 32-bit instance
// checks the wider configuration and its 5-cycle latency.
module tb_barrel_shifter_pipe;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   // 8-bit instance
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic [2:0] in_amt = 3'd0;
   logic [1:0] in_mode = 2'b00;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;

   // 32-bit instance
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [31:0] b_in_data = 32'h0;
   logic [4:0]  b_in_amt = 5'd0;
   logic [1:0]  b_in_mode = 2'b00;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic [31:0] b_out_data;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [7:0] got_data[$];
   int         got_cyc[$];

   barrel_shifter_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   barrel_shifter_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_amt(b_in_amt), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output transfer of the 8-bit instance (sampled mid-cycle)
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_cyc.push_back(cyc);
      end
   end

   // Bit-by-bit reference: out[i] taken from the source index the mode defines
   function automatic logic [7:0] model8(logic [7:0] d, logic [2:0] a, logic [1:0] m);
      logic [7:0] r;
      int n;
      r = 8'h00;
      n = int'(a);
      for (int i = 0; i < 8; i++) begin
         case (m)
            2'b00:   r[i] = d[(i + n) % 8];
            2'b01:   r[i] = d[(i + 8 - n) % 8];
            2'b10:   r[i] = (i + n < 8) ? d[(i + n) % 8] : 1'b0;
            default: r[i] = (i + n < 8) ? d[(i + n) % 8] : d[7];
         endcase
      end
      return r;
   endfunction

   task automatic test_reset;
      #2 reset_n = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset32_out_valid: got %b want 0", b_out_valid); end
      tests_run++; if (b_out_data !== 32'h0) begin tests_failed++; $display("FAIL reset32_out_data: got %h want 0", b_out_data); end
      tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset32_in_ready: got %b want 1", b_in_ready); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One operand through an empty pipe: latency, value, and no duplicate
   task automatic test_single8(string nm, logic [7:0] d, logic [2:0] a, logic [1:0] m, logic [7:0] exp);
      int n;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'h00;
      n = 1;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL %s latency: got %0d want 3", nm, n); end
      tests_run++; if (out_data !== exp) begin tests_failed++; $display("FAIL %s data: got %h want %h", nm, out_data, exp); end
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL %s single_beat: got out_valid %b want 0", nm, out_valid); end
   endtask

   task automatic test_single32(string nm, logic [31:0] d, logic [4:0] a, logic [1:0] m, logic [31:0] exp);
      int n;
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_data = d; b_in_amt = a; b_in_mode = m;
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_in_data = 32'h0;
      n = 1;
      while (!b_out_valid && n < 20) begin @(posedge clk); #1; n++; end
      tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL %s latency: got %0d want 5", nm, n); end
      tests_run++; if (b_out_data !== exp) begin tests_failed++; $display("FAIL %s data: got %h want %h", nm, b_out_data, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_modes;
      test_single8("ror3", 8'b1001_0110, 3'd3, 2'b00, 8'b1101_0010);
      test_single8("rol3", 8'b1001_0110, 3'd3, 2'b01, 8'b1011_0100);
      test_single8("lsr5", 8'hF0, 3'd5, 2'b10, 8'h07);
      test_single8("asr3", 8'h90, 3'd3, 2'b11, 8'hF2);
      test_single8("asr7_pos", 8'h70, 3'd7, 2'b11, 8'h00);
      test_single8("asr7_neg", 8'h80, 3'd7, 2'b11, 8'hFF);
      test_single8("ror0", 8'hA5, 3'd0, 2'b00, 8'hA5);
      test_single8("rol0", 8'hA5, 3'd0, 2'b01, 8'hA5);
      test_single8("lsr0", 8'hA5, 3'd0, 2'b10, 8'hA5);
      test_single8("asr0", 8'hA5, 3'd0, 2'b11, 8'hA5);
   endtask

   task automatic test_back_to_back;
      logic [7:0] vd[16];
      logic [2:0] va[16];
      logic [1:0] vm[16];
      got_data.delete(); got_cyc.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         vd[i] = 8'($urandom_range(0, 255));
         va[i] = 3'($urandom_range(0, 7));
         vm[i] = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = vd[i]; in_amt = va[i]; in_mode = vm[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (8) @(posedge clk); #1;
      tests_run++; if (got_data.size() !== 16) begin tests_failed++; $display("FAIL b2b_count: got %0d want 16", got_data.size()); end
      for (int i = 0; i < 16 && i < got_data.size(); i++) begin
         tests_run++;
         if (got_data[i] !== model8(vd[i], va[i], vm[i])) begin
            tests_failed++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_data[i], model8(vd[i], va[i], vm[i]));
         end
         if (i > 0) begin
            tests_run++;
            if (got_cyc[i] !== got_cyc[0] + i) begin
               tests_failed++; $display("FAIL b2b_spacing[%0d]: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] vd[8] = '{8'h96, 8'h3C, 8'h81, 8'hF0, 8'h55, 8'h90, 8'h0F, 8'hE7};
      logic [2:0] va[8] = '{3'd3, 3'd1, 3'd7, 3'd4, 3'd2, 3'd6, 3'd5, 3'd0};
      logic [1:0] vm[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10};
      int  idx;
      logic acc;
      got_data.delete(); got_cyc.delete();
      idx = 0;
      for (int t = 0; t < 30; t++) begin
         out_ready = !(t >= 3 && t < 8);
         in_valid = (idx < 8);
         if (idx < 8) begin in_data = vd[idx]; in_amt = va[idx]; in_mode = vm[idx]; end
         #1;
         if (t >= 3 && t < 8) begin
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready t=%0d: got %b want 0", t, in_ready); end
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== model8(vd[0], va[0], vm[0])) begin
               tests_failed++; $display("FAIL bp_hold t=%0d: got valid %b data %h want 1 %h", t, out_valid, out_data, model8(vd[0], va[0], vm[0]));
            end
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tests_run++; if (got_data.size() !== 8) begin tests_failed++; $display("FAIL bp_count: got %0d want 8", got_data.size()); end
      for (int i = 0; i < 8 && i < got_data.size(); i++) begin
         tests_run++;
         if (got_data[i] !== model8(vd[i], va[i], vm[i])) begin
            tests_failed++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], model8(vd[i], va[i], vm[i]));
         end
         if (i > 0) begin
            tests_run++;
            if (got_cyc[i] !== got_cyc[0] + i) begin
               tests_failed++; $display("FAIL bp_spacing[%0d]: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
            end
         end
      end
   endtask

   task automatic test_reset_midstream;
      got_data.delete(); got_cyc.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'h11 * 8'(i + 1); in_amt = 3'(i + 1); in_mode = 2'b00;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_full: got out_valid %b want 1", out_valid); end
      reset_n = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_immediate: got out_valid %b want 0", out_valid); end
      tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h want 00", out_data); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      tests_run++; if (got_data.size() !== 0) begin tests_failed++; $display("FAIL rst_discard: got %0d results want 0", got_data.size()); end
      test_single8("post_reset", 8'h96, 3'd3, 2'b00, 8'hD2);
   endtask

   task automatic test_width32;
      test_single32("ror32", 32'h8000_0001, 5'd1, 2'b00, 32'hC000_0000);
      test_single32("asr32", 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF);
      test_single32("lsr32", 32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001);
      test_single32("rol32", 32'h8000_0001, 5'd4, 2'b01, 32'h0000_0018);
   endtask

   initial begin
      test_reset();
      test_modes();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_width32();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
